csr_arbiter: RTL and testbench

//  Shares one downstream CSR slave port between N CSR masters (CPU core, debug, DMA, ...).

---
 rtl/csr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_csr_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_arbiter.sv
// Round-robin arbiter sharing one CSR slave port between N_REQ masters, one outstanding transaction.
// Optional response watchdog (TOUT/DRAIN states) enabled by defining CSR_ARB_TIMEOUT_EN.
module csr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PRIV_W  = 2,
    parameter int TIMEOUT = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             m_req_valid,
    output logic [N_REQ-1:0]             m_req_ready,
    input  logic [N_REQ-1:0]             m_req_write,
    input  logic [N_REQ*ADDR_W-1:0]      m_req_addr,
    input  logic [N_REQ*DATA_W-1:0]      m_req_wdata,
    input  logic [N_REQ*DATA_W/8-1:0]    m_req_wstrb,
    input  logic [N_REQ*PRIV_W-1:0]      m_req_priv,
    output logic [N_REQ-1:0]             m_rsp_valid,
    input  logic [N_REQ-1:0]             m_rsp_ready,
    output logic [DATA_W-1:0]            m_rsp_rdata,
    output logic                         m_rsp_fault,
    output logic                         s_req_valid,
    output logic                         s_req_write,
    output logic [ADDR_W-1:0]            s_req_addr,
    output logic [DATA_W-1:0]            s_req_wdata,
    output logic [DATA_W/8-1:0]          s_req_wstrb,
    output logic [PRIV_W-1:0]            s_req_priv,
    input  logic                         s_req_ready,
    input  logic                         s_rsp_valid,
    input  logic [DATA_W-1:0]            s_rsp_rdata,
    input  logic                         s_rsp_fault,
    output logic                         s_rsp_ready,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int STRB_W = DATA_W / 8;

`ifdef CSR_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    typedef enum logic [2:0] {IDLE, REQ, RSP, TOUT, DRAIN} state_t;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
`endif

    state_t          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] next_ptr;
    logic            found;
    int unsigned     scan_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
`ifdef CSR_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef CSR_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = (32'(rr_ptr_q) + i) % 32'(N_REQ);
            if (!found && m_req_valid[scan_idx]) begin
                winner = ID_W'(scan_idx);
                found  = 1'b1;
            end
        end
    end

    assign next_ptr = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef CSR_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        m_req_ready = '0;
        m_rsp_valid = '0;
        m_rsp_rdata = '0;
        m_rsp_fault = 1'b0;
        s_req_valid = 1'b0;
        s_req_write = 1'b0;
        s_req_addr  = '0;
        s_req_wdata = '0;
        s_req_wstrb = '0;
        s_req_priv  = '0;
        s_rsp_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                s_req_valid          = 1'b1;
                s_req_write          = m_req_write[owner_q];
                s_req_addr           = m_req_addr[32'(owner_q)*ADDR_W +: ADDR_W];
                s_req_wdata          = m_req_wdata[32'(owner_q)*DATA_W +: DATA_W];
                s_req_wstrb          = m_req_wstrb[32'(owner_q)*STRB_W +: STRB_W];
                s_req_priv           = m_req_priv[32'(owner_q)*PRIV_W +: PRIV_W];
                m_req_ready[owner_q] = s_req_ready;
                if (s_req_ready) begin
                    state_d = RSP;
`ifdef CSR_ARB_TIMEOUT_EN
                    cnt_d   = CNT_W'(TIMEOUT - 1);
`endif
                end
            end
            RSP: begin
                m_rsp_valid[owner_q] = s_rsp_valid;
                s_rsp_ready          = m_rsp_ready[owner_q];
                m_rsp_rdata          = s_rsp_rdata;
                m_rsp_fault          = s_rsp_fault;
                if (s_rsp_valid && m_rsp_ready[owner_q]) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
`ifdef CSR_ARB_TIMEOUT_EN
                else if (!s_rsp_valid) begin
                    if (cnt_q == '0) state_d = TOUT;
                    else             cnt_d   = cnt_q - 1'b1;
                end
`endif
            end
`ifdef CSR_ARB_TIMEOUT_EN
            TOUT: begin
                m_rsp_valid[owner_q] = 1'b1;
                m_rsp_fault          = 1'b1;
                // A timed-out owner still counts as served for fairness.
                if (m_rsp_ready[owner_q]) begin
                    rr_ptr_d = next_ptr;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                s_rsp_ready = 1'b1;
                if (s_rsp_valid) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign grant_id = owner_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_csr_arbiter.sv
// Self-checking bench for csr_arbiter: directed scenarios plus randomized traffic vs. a transaction model.
// The watchdog scenario runs only when CSR_ARB_TIMEOUT_EN is defined.
module tb_csr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 2;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0]    m_req_valid, m_req_ready, m_req_write, m_rsp_valid, m_rsp_ready;
    logic [N*AW-1:0] m_req_addr;
    logic [N*DW-1:0] m_req_wdata;
    logic [N*SW-1:0] m_req_wstrb;
    logic [N*PW-1:0] m_req_priv;
    logic [DW-1:0]   m_rsp_rdata;
    logic            m_rsp_fault;
    logic            s_req_valid, s_req_write, s_req_ready, s_rsp_valid, s_rsp_fault, s_rsp_ready;
    logic [AW-1:0]   s_req_addr;
    logic [DW-1:0]   s_req_wdata, s_rsp_rdata;
    logic [SW-1:0]   s_req_wstrb;
    logic [PW-1:0]   s_req_priv;
    logic [1:0]      grant_id;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int req_hs = 0;
    int rsp_hs = 0;

    always #5 clk = ~clk;

    csr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .PRIV_W(PW), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_write(m_req_write),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_req_priv(m_req_priv), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .m_rsp_fault(m_rsp_fault),
        .s_req_valid(s_req_valid), .s_req_write(s_req_write), .s_req_addr(s_req_addr),
        .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb), .s_req_priv(s_req_priv),
        .s_req_ready(s_req_ready), .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_fault(s_rsp_fault), .s_rsp_ready(s_rsp_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always @(posedge clk) begin
        if (s_req_valid && s_req_ready) req_hs++;
        if (s_rsp_valid && s_rsp_ready) rsp_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_req_valid = '0; m_req_write = '0; m_req_addr = '0; m_req_wdata = '0;
        m_req_wstrb = '0; m_req_priv = '0; m_rsp_ready = '0;
        s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_rdata = '0; s_rsp_fault = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_master(input int i, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [PW-1:0] p);
        m_req_valid[i] = 1'b1;
        m_req_write[i] = w;
        m_req_addr[i*AW +: AW]  = a;
        m_req_wdata[i*DW +: DW] = d;
        m_req_wstrb[i*SW +: SW] = s;
        m_req_priv[i*PW +: PW]  = p;
    endtask

    // Steps cycles until s_req_valid is seen at a falling edge, giving up after 12 cycles.
    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (s_req_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        m_req_valid = '1; m_rsp_ready = '1; s_req_ready = 1'b1; s_rsp_valid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, grant_id, m_req_ready, m_rsp_valid, s_req_valid, s_rsp_ready, s_req_addr, s_req_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b gid=%0d mrdy=%b mrspv=%b sreqv=%b srsprdy=%b addr=%h",
                     busy, grant_id, m_req_ready, m_rsp_valid, s_req_valid, s_rsp_ready, s_req_addr);
        end
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        int rb;
        apply_reset();
        set_master(0, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 2'd3);
        s_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, m_req_ready} !== 5'b0) begin
            errors++; $display("FAIL single_idle: busy=%b mrdy=%b expected 0", busy, m_req_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({s_req_valid, s_req_write, s_req_addr, s_req_wdata, s_req_wstrb, s_req_priv, m_req_ready, grant_id, busy}
            !== {1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 2'd3, 4'b0001, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_req_fields: v=%b w=%b a=%h d=%h s=%h p=%0d rdy=%b gid=%0d expected 1 1 10 a5a5a5a5 f 3 0001 0",
                     s_req_valid, s_req_write, s_req_addr, s_req_wdata, s_req_wstrb, s_req_priv, m_req_ready, grant_id);
        end
        tick();
        m_req_valid = '0; s_req_ready = 1'b0;
        s_rsp_valid = 1'b1; s_rsp_rdata = '0; s_rsp_fault = 1'b0; m_rsp_ready = 4'b0001;
        rb = rsp_hs;
        @(negedge clk);
        checks++;
        if ({m_rsp_valid, m_rsp_fault, s_rsp_ready, s_req_valid, busy} !== {4'b0001, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL single_rsp: rspv=%b fault=%b srdy=%b sreqv=%b busy=%b expected 0001 0 1 0 1",
                     m_rsp_valid, m_rsp_fault, s_rsp_ready, s_req_valid, busy);
        end
        tick();
        s_rsp_valid = 1'b0; m_rsp_ready = '0;
        @(negedge clk);
        checks++;
        if ({busy, m_rsp_valid} !== 5'b0 || rsp_hs - rb !== 1) begin
            errors++;
            $display("FAIL single_done: busy=%b rspv=%b rsp_hs=%0d expected 0 0000 1", busy, m_rsp_valid, rsp_hs - rb);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 1, 1};
        bit got;
        int gid;
        apply_reset();
        s_req_ready = 1'b1; s_rsp_valid = 1'b1; s_rsp_rdata = 32'h77; m_rsp_ready = '1;
        for (int i = 0; i < 3; i++) set_master(i, 1'b0, 32'h100 + i, 32'h0, 4'h0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            wait_req(got);
            gid = int'(grant_id);
            checks++;
            if (!got || gid != exp_order[k] || s_req_addr !== 32'h100 + exp_order[k]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got_req=%0d gid=%0d addr=%h expected gid=%0d addr=%h",
                         k, got, gid, s_req_addr, exp_order[k], 32'h100 + exp_order[k]);
            end
            tick();
            if (gid != 1) m_req_valid[gid] = 1'b0;
        end
        m_req_valid = '0;
        repeat (3) tick();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        bit got;
        int qb, rb;
        apply_reset();
        set_master(2, 1'b0, 32'h2000, 32'hCAFE_0002, 4'h3, 2'd1);
        qb = req_hs;
        wait_req(got);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (!got || {s_req_valid, s_req_write, s_req_addr, s_req_wdata, s_req_wstrb, s_req_priv, m_req_ready, m_rsp_valid}
                !== {1'b1, 1'b0, 32'h2000, 32'hCAFE_0002, 4'h3, 2'd1, 4'b0, 4'b0}) begin
                errors++;
                $display("FAIL bp_req_hold[%0d]: v=%b a=%h d=%h rdy=%b expected 1 2000 cafe0002 0000",
                         c, s_req_valid, s_req_addr, s_req_wdata, m_req_ready);
            end
            tick();
        end
        s_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_req_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_req_ready: got %b expected 0100", m_req_ready);
        end
        tick();
        m_req_valid = '0; s_req_ready = 1'b0;
        rb = rsp_hs;
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h1234; m_rsp_ready = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({m_rsp_valid, m_rsp_rdata, s_rsp_ready} !== {4'b0100, 32'h1234, 1'b0}) begin
                errors++;
                $display("FAIL bp_rsp_hold[%0d]: rspv=%b rdata=%h srdy=%b expected 0100 1234 0",
                         c, m_rsp_valid, m_rsp_rdata, s_rsp_ready);
            end
            tick();
        end
        m_rsp_ready = '1;
        @(negedge clk);
        checks++;
        if ({s_rsp_ready, m_rsp_valid} !== {1'b1, 4'b0100}) begin
            errors++; $display("FAIL bp_rsp_accept: srdy=%b rspv=%b expected 1 0100", s_rsp_ready, m_rsp_valid);
        end
        tick();
        s_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_hs - qb !== 1 || rsp_hs - rb !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshakes: req=%0d rsp=%0d busy=%b expected 1 1 0", req_hs - qb, rsp_hs - rb, busy);
        end
    endtask

    task automatic test_fault();
        bit got;
        apply_reset();
        set_master(3, 1'b0, 32'h30, 32'h0, 4'h0, 2'd2);
        s_req_ready = 1'b1;
        wait_req(got);
        checks++;
        if (!got || grant_id !== 2'd3) begin
            errors++; $display("FAIL fault_grant: got_req=%0d gid=%0d expected 3", got, grant_id);
        end
        tick();
        m_req_valid = '0; s_req_ready = 1'b0;
        s_rsp_valid = 1'b1; s_rsp_fault = 1'b1; s_rsp_rdata = 32'hDEAD_BEEF; m_rsp_ready = 4'b1000;
        @(negedge clk);
        checks++;
        if ({m_rsp_valid, m_rsp_fault, m_rsp_rdata} !== {4'b1000, 1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL fault_rsp: rspv=%b fault=%b rdata=%h expected 1000 1 deadbeef", m_rsp_valid, m_rsp_fault, m_rsp_rdata);
        end
        tick();
        s_rsp_valid = 1'b0; s_rsp_fault = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL fault_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        apply_reset();
        set_master(1, 1'b1, 32'h44, 32'h1, 4'h1, 2'd0);
        s_req_ready = 1'b1;
        wait_req(got);
        tick();
        s_rsp_valid = 1'b1; m_rsp_ready = 4'b0000;
        @(negedge clk);
        checks++;
        if (!got || busy !== 1'b1 || m_rsp_valid !== 4'b0010) begin
            errors++; $display("FAIL rmid_in_rsp: got_req=%0d busy=%b rspv=%b expected 1 1 0010", got, busy, m_rsp_valid);
        end
        rst_n = 1'b0;
        m_rsp_ready = '1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_req_ready, m_rsp_valid, s_req_valid, s_rsp_ready, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs: mrdy=%b rspv=%b sreqv=%b srdy=%b busy=%b gid=%0d expected all 0",
                     m_req_ready, m_rsp_valid, s_req_valid, s_rsp_ready, busy, grant_id);
        end
        tick();
        rst_n = 1'b1; s_rsp_valid = 1'b0;
        for (int i = 0; i < N; i++) set_master(i, 1'b0, 32'h500 + i, 32'h0, 4'h0, 2'd0);
        wait_req(got);
        checks++;
        if (!got || grant_id !== 2'd0 || s_req_addr !== 32'h500) begin
            errors++; $display("FAIL rmid_first_grant: got_req=%0d gid=%0d addr=%h expected 0 500", got, grant_id, s_req_addr);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int phase = 0, ptr = 0, ex = 0, ntx = 0, dly = 0;
        int wait_cnt [N] = '{default: 0};
        bit pend = 1'b0, req_done = 1'b0, rsp_done = 1'b0;
        logic [N-1:0] acc = '0;
        logic [N-1:0] oh;
        apply_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (m_req_valid[i] && acc[i]) m_req_valid[i] = 1'b0;
                else if (!m_req_valid[i] && $urandom_range(0, 3) == 0)
                    set_master(i, 1'($urandom), $urandom, $urandom, 4'($urandom), 2'($urandom));
            end
            m_rsp_ready = 4'($urandom);
            s_req_ready = 1'($urandom);
            if (rsp_done) begin s_rsp_valid = 1'b0; pend = 1'b0; end
            if (req_done) begin pend = 1'b1; dly = $urandom_range(0, 4); end
            if (pend && !s_rsp_valid) begin
                if (dly == 0) begin
                    s_rsp_valid = 1'b1; s_rsp_rdata = $urandom; s_rsp_fault = 1'($urandom);
                end else dly--;
            end
            @(negedge clk);
            oh = 4'b0001 << ex;
            checks++;
            case (phase)
                0: begin
                    if ({busy, m_req_ready, m_rsp_valid, s_req_valid, s_rsp_ready} !== '0) begin
                        errors++;
                        $display("FAIL rnd_idle cyc%0d: busy=%b mrdy=%b rspv=%b sreqv=%b expected all 0",
                                 cyc, busy, m_req_ready, m_rsp_valid, s_req_valid);
                    end
                    if (|m_req_valid) begin
                        for (int k = 0; k < N; k++) if (m_req_valid[(ptr + k) % N]) begin ex = (ptr + k) % N; break; end
                        for (int j = 0; j < N; j++) if (m_req_valid[j] && j != ex) wait_cnt[j]++;
                        checks++;
                        if (wait_cnt[ex] > N - 1) begin
                            errors++; $display("FAIL rnd_fair cyc%0d: master %0d waited %0d limit %0d", cyc, ex, wait_cnt[ex], N - 1);
                        end
                        wait_cnt[ex] = 0;
                        phase = 1;
                    end
                end
                1: begin
                    if ({s_req_valid, busy, grant_id, s_req_write, s_req_addr, s_req_wdata, s_req_wstrb, s_req_priv, m_req_ready}
                        !== {1'b1, 1'b1, 2'(ex), m_req_write[ex], m_req_addr[ex*AW +: AW], m_req_wdata[ex*DW +: DW],
                             m_req_wstrb[ex*SW +: SW], m_req_priv[ex*PW +: PW], s_req_ready ? oh : 4'b0}) begin
                        errors++;
                        $display("FAIL rnd_req cyc%0d: v=%b gid=%0d addr=%h rdy=%b expected gid=%0d addr=%h",
                                 cyc, s_req_valid, grant_id, s_req_addr, m_req_ready, ex, m_req_addr[ex*AW +: AW]);
                    end
                    if (s_req_ready) phase = 2;
                end
                default: begin
                    if (m_rsp_valid !== (s_rsp_valid ? oh : 4'b0) || s_rsp_ready !== m_rsp_ready[ex] ||
                        (s_rsp_valid && {m_rsp_rdata, m_rsp_fault} !== {s_rsp_rdata, s_rsp_fault})) begin
                        errors++;
                        $display("FAIL rnd_rsp cyc%0d: rspv=%b srdy=%b rdata=%h fault=%b expected owner %0d rdata=%h fault=%b",
                                 cyc, m_rsp_valid, s_rsp_ready, m_rsp_rdata, m_rsp_fault, ex, s_rsp_rdata, s_rsp_fault);
                    end
                    if (s_rsp_valid && m_rsp_ready[ex]) begin
                        ptr = (ex + 1) % N; phase = 0; ntx++;
                    end
                end
            endcase
            acc      = m_req_ready & m_req_valid;
            req_done = s_req_valid && s_req_ready;
            rsp_done = s_rsp_valid && s_rsp_ready;
        end
        checks++;
        if (ntx < 20) begin
            errors++; $display("FAIL rnd_progress: %0d transactions completed, need at least 20", ntx);
        end
        idle_inputs();
    endtask

`ifdef CSR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit got;
        apply_reset();
        set_master(0, 1'b0, 32'h60, 32'h0, 4'h0, 2'd0);
        s_req_ready = 1'b1;
        wait_req(got);
        tick();
        m_req_valid = '0; s_req_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (!got || m_rsp_valid !== 4'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL tout_wait[%0d]: rspv=%b busy=%b expected 0000 1", c, m_rsp_valid, busy);
            end
            tick();
        end
        m_rsp_ready = 4'b0001;
        @(negedge clk);
        checks++;
        if ({m_rsp_valid, m_rsp_fault, m_rsp_rdata, s_rsp_ready} !== {4'b0001, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL tout_fire: rspv=%b fault=%b rdata=%h srdy=%b expected 0001 1 0 0",
                     m_rsp_valid, m_rsp_fault, m_rsp_rdata, s_rsp_ready);
        end
        tick();
        m_rsp_ready = '1;
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h5555;
        @(negedge clk);
        checks++;
        if ({m_rsp_valid, s_rsp_ready, busy} !== {4'b0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL tout_drain: rspv=%b srdy=%b busy=%b expected 0000 1 1", m_rsp_valid, s_rsp_ready, busy);
        end
        tick();
        s_rsp_valid = 1'b0; m_rsp_ready = '0;
        set_master(1, 1'b0, 32'h61, 32'h0, 4'h0, 2'd0);
        s_req_ready = 1'b1;
        wait_req(got);
        checks++;
        if (!got || grant_id !== 2'd1 || m_rsp_valid !== 4'b0) begin
            errors++; $display("FAIL tout_next_grant: got_req=%0d gid=%0d rspv=%b expected 1 0000", got, grant_id, m_rsp_valid);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_backpressure();
        test_fault();
        test_reset_mid();
        test_random();
`ifdef CSR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
